// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Control/status bundle between the control decoder (master) and the
//   program-counter sequencer (slave).
//
//   Strobes (master -> slave):
//     en       advance enable, 0 = stall
//     branch   take relative branch by 'offset'
//     offset   two's-complement branch offset
//     jump     absolute jump to 'target'
//     target   jump/call destination
//     call     push return address, go to 'target'
//     ret      pop return address into pc
//   Status (slave -> master):
//     pc, pc_next, stack_full, stack_empty, stack_err
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 8
);

  logic             en;
  logic             branch;
  logic [WIDTH-1:0] offset;
  logic             jump;
  logic [WIDTH-1:0] target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  modport master (
    output en, branch, offset, jump, target, call, ret,
    input  pc, pc_next, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  en, branch, offset, jump, target, call, ret,
    output pc, pc_next, stack_full, stack_empty, stack_err
  );

endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter unit with a LIFO return-address stack. Each enabled
//   cycle the next pc is chosen by priority ret > call > jump > branch >
//   increment. All arithmetic wraps modulo 2**WIDTH silently.
//
//   Ports:
//     clk    rising-edge clock for all state
//     rst_n  synchronous active-low reset (pc <= RESET_VEC, stack emptied,
//            stack_err cleared); overrides en and all strobes
//     bus    pc_sequencer_if.slave: strobes in, pc/pc_next/stack status out
//
//   Parameters:
//     WIDTH        pc/address width
//     RESET_VEC    pc value after reset
//     STEP         sequential increment
//     STACK_DEPTH  return-address stack entries (>= 1)
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter logic [WIDTH-1:0] STEP        = WIDTH'(1),
  parameter int unsigned      STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave bus
);

  // sp counts entries 0..STACK_DEPTH, so it needs one more code than the
  // entry index does.
  localparam int unsigned SP_W      = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned MEM_DEPTH = 1 << IDX_W;

  localparam logic [SP_W-1:0] SP_ZERO = '0;
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  // Source of the next pc value.
  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_INC,
    SRC_BRANCH,
    SRC_JUMP,
    SRC_CALL,
    SRC_RET
  } src_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_q;
  logic [SP_W-1:0]  sp_q;
  logic             err_q;
  logic [WIDTH-1:0] stack_mem [MEM_DEPTH];

  // -------------------------------------------------------------------------
  // Derived values
  // -------------------------------------------------------------------------
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_rel;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic [WIDTH-1:0] top_val;

  assign full     = (sp_q == SP_FULL);
  assign empty    = (sp_q == SP_ZERO);
  assign pc_inc   = pc_q + STEP;
  // Two's-complement offset added with modular arithmetic gives the signed
  // displacement without any explicit sign extension.
  assign pc_rel   = pc_q + bus.offset;
  // Only meaningful when the stack is non-empty; the wrapped value at sp=0
  // is never selected.
  assign top_idx  = IDX_W'(sp_q - SP_ONE);
  assign push_idx = IDX_W'(sp_q);
  assign top_val  = stack_mem[top_idx];

  // -------------------------------------------------------------------------
  // Decode: pick the pc source and the stack action
  // -------------------------------------------------------------------------
  src_e src;
  logic push;
  logic pop;
  logic err_set;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    src     = SRC_HOLD;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (bus.en) begin
      if (bus.ret) begin
        if (!empty) begin
          src = SRC_RET;
          pop = 1'b1;
        end else begin
          // Underflow: fall through to a normal advance and flag it.
          src     = SRC_INC;
          err_set = 1'b1;
        end
      end else if (bus.call) begin
        // The jump to target happens even when the push is dropped.
        src = SRC_CALL;
        if (!full) begin
          push = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end else if (bus.jump) begin
        src = SRC_JUMP;
      end else if (bus.branch) begin
        src = SRC_BRANCH;
      end else begin
        src = SRC_INC;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-pc mux
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_nxt;

  always_comb begin
    pc_nxt = pc_q;
    unique case (src)
      SRC_HOLD:   pc_nxt = pc_q;
      SRC_INC:    pc_nxt = pc_inc;
      SRC_BRANCH: pc_nxt = pc_rel;
      SRC_JUMP:   pc_nxt = bus.target;
      SRC_CALL:   pc_nxt = bus.target;
      SRC_RET:    pc_nxt = top_val;
      default:    pc_nxt = pc_q;
    endcase
  end

  logic [SP_W-1:0] sp_nxt;

  always_comb begin
    sp_nxt = sp_q;
    if (push) begin
      sp_nxt = sp_q + SP_ONE;
    end else if (pop) begin
      sp_nxt = sp_q - SP_ONE;
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      sp_q  <= SP_ZERO;
      err_q <= 1'b0;
    end else begin
      // With en=0 the decode yields SRC_HOLD and no stack action, so the
      // same assignments implement the stall.
      pc_q  <= pc_nxt;
      sp_q  <= sp_nxt;
      err_q <= err_q | err_set;
    end
  end

  // -------------------------------------------------------------------------
  // Return-address storage
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset; emptiness is tracked by sp alone,
  // which keeps the array a plain register file / RAM.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.pc          = pc_q;
  assign bus.pc_next     = pc_nxt;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer (WIDTH=8, RESET_VEC=0, STEP=1,
//   STACK_DEPTH=4). Inputs change 1 time unit after a rising edge and
//   outputs are compared at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pc_sequencer_if #(.WIDTH(8)) bus ();

  pc_sequencer #(
    .WIDTH      (8),
    .RESET_VEC  (8'h00),
    .STEP       (8'h01),
    .STACK_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    bus.branch = 1'b0;
    bus.offset = 8'h00;
    bus.jump   = 1'b0;
    bus.target = 8'h00;
    bus.call   = 1'b0;
    bus.ret    = 1'b0;
  endtask

  task automatic go_to(input logic [7:0] addr);
    idle_strobes();
    bus.en     = 1'b1;
    bus.jump   = 1'b1;
    bus.target = addr;
    tick();
    idle_strobes();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n  = 1'b0;
    bus.en = 1'b0;
    idle_strobes();
    tick();
    tick();
    checks++;
    if (bus.pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_pc: got %h expected 00", bus.pc);
    end
    checks++;
    if (bus.stack_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty: got %b expected 1", bus.stack_empty);
    end
    checks++;
    if (bus.stack_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_full: got %b expected 0", bus.stack_full);
    end
    checks++;
    if (bus.stack_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", bus.stack_err);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_increment();
    logic [7:0] exp_pc;
    rst_n  = 1'b1;
    bus.en = 1'b1;
    idle_strobes();
    #1;
    checks++;
    if (bus.pc_next !== 8'h01) begin
      errors++;
      $display("FAIL inc_pc_next: got %h expected 01", bus.pc_next);
    end
    exp_pc = 8'h00;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_pc = exp_pc + 8'h01;
      checks++;
      if (bus.pc !== exp_pc) begin
        errors++;
        $display("FAIL inc_step%0d: got %h expected %h", i, bus.pc, exp_pc);
      end
    end
    go_to(8'hFF);
    tick();
    checks++;
    if (bus.pc !== 8'h00) begin
      errors++;
      $display("FAIL inc_wrap: got %h expected 00", bus.pc);
    end
    checks++;
    if (bus.stack_err !== 1'b0) begin
      errors++;
      $display("FAIL inc_wrap_err: got %b expected 0", bus.stack_err);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_branch_jump();
    go_to(8'h10);
    bus.branch = 1'b1;
    bus.offset = 8'hF8;
    tick();
    checks++;
    if (bus.pc !== 8'h08) begin
      errors++;
      $display("FAIL branch_back: got %h expected 08", bus.pc);
    end
    bus.jump   = 1'b1;
    bus.target = 8'h80;
    tick();
    checks++;
    if (bus.pc !== 8'h80) begin
      errors++;
      $display("FAIL jump_over_branch: got %h expected 80", bus.pc);
    end
    go_to(8'h02);
    bus.branch = 1'b1;
    bus.offset = 8'hFC;
    tick();
    checks++;
    if (bus.pc !== 8'hFE) begin
      errors++;
      $display("FAIL branch_wrap: got %h expected FE", bus.pc);
    end
    bus.offset = 8'h05;
    tick();
    checks++;
    if (bus.pc !== 8'h03) begin
      errors++;
      $display("FAIL branch_fwd_wrap: got %h expected 03", bus.pc);
    end
    idle_strobes();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_call_ret();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'h40, 8'h60, 8'h41, 8'h06};
    go_to(8'h05);
    for (int i = 0; i < 4; i++) begin
      idle_strobes();
      if (i == 0) begin
        bus.call = 1'b1; bus.target = 8'h40;
      end else if (i == 1) begin
        bus.call = 1'b1; bus.target = 8'h60;
      end else begin
        bus.ret = 1'b1;
      end
      tick();
      checks++;
      if (bus.pc !== exp_seq[i]) begin
        errors++;
        $display("FAIL nest_step%0d: got %h expected %h", i, bus.pc, exp_seq[i]);
      end
    end
    idle_strobes();
    checks++;
    if (bus.stack_empty !== 1'b1) begin
      errors++;
      $display("FAIL nest_empty: got %b expected 1", bus.stack_empty);
    end
    checks++;
    if (bus.stack_err !== 1'b0) begin
      errors++;
      $display("FAIL nest_err: got %b expected 0", bus.stack_err);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_overflow_underflow();
    logic [7:0] call_tgt [5];
    logic [7:0] ret_exp  [5];
    call_tgt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
    // Pushed: 21, A1, A2, A3; the 5th push is dropped. Last ret underflows
    // and advances 0x21 -> 0x22.
    ret_exp  = '{8'hA3, 8'hA2, 8'hA1, 8'h21, 8'h22};
    go_to(8'h20);
    for (int i = 0; i < 5; i++) begin
      bus.call   = 1'b1;
      bus.target = call_tgt[i];
      tick();
      checks++;
      if (bus.pc !== call_tgt[i]) begin
        errors++;
        $display("FAIL ovf_call%0d_pc: got %h expected %h", i, bus.pc, call_tgt[i]);
      end
      if (i == 3) begin
        checks++;
        if (bus.stack_full !== 1'b1 || bus.stack_err !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full4: got full=%b err=%b expected full=1 err=0",
                   bus.stack_full, bus.stack_err);
        end
      end
    end
    checks++;
    if (bus.stack_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_err: got %b expected 1", bus.stack_err);
    end
    idle_strobes();
    for (int i = 0; i < 5; i++) begin
      bus.ret = 1'b1;
      if (i == 4) begin
        #1;
        checks++;
        if (bus.pc_next !== 8'h22) begin
          errors++;
          $display("FAIL udf_pc_next: got %h expected 22", bus.pc_next);
        end
      end
      tick();
      checks++;
      if (bus.pc !== ret_exp[i]) begin
        errors++;
        $display("FAIL udf_ret%0d_pc: got %h expected %h", i, bus.pc, ret_exp[i]);
      end
    end
    idle_strobes();
    checks++;
    if (bus.stack_empty !== 1'b1 || bus.stack_err !== 1'b1) begin
      errors++;
      $display("FAIL udf_flags: got empty=%b err=%b expected empty=1 err=1",
               bus.stack_empty, bus.stack_err);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_stall();
    // pc=0x22 here; call pushes 0x23.
    bus.call   = 1'b1;
    bus.target = 8'h70;
    tick();
    bus.en     = 1'b0;
    bus.target = 8'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.pc_next !== 8'h70) begin
        errors++;
        $display("FAIL stall%0d_pc_next: got %h expected 70", i, bus.pc_next);
      end
      tick();
      checks++;
      if (bus.pc !== 8'h70 || bus.stack_empty !== 1'b0 || bus.stack_full !== 1'b0
          || bus.stack_err !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d_state: got pc=%h empty=%b full=%b err=%b expected pc=70 empty=0 full=0 err=1",
                 i, bus.pc, bus.stack_empty, bus.stack_full, bus.stack_err);
      end
    end
    idle_strobes();
    bus.en  = 1'b1;
    bus.ret = 1'b1;
    tick();
    checks++;
    if (bus.pc !== 8'h23 || bus.stack_empty !== 1'b1) begin
      errors++;
      $display("FAIL stall_ret: got pc=%h empty=%b expected pc=23 empty=1",
               bus.pc, bus.stack_empty);
    end
    idle_strobes();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    bus.call   = 1'b1;
    bus.target = 8'h30;
    tick();
    bus.target = 8'h40;
    tick();
    idle_strobes();
    checks++;
    if (bus.stack_empty !== 1'b0 || bus.stack_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got empty=%b err=%b expected empty=0 err=1",
               bus.stack_empty, bus.stack_err);
    end
    rst_n   = 1'b0;
    bus.ret = 1'b1;
    tick();
    checks++;
    if (bus.pc !== 8'h00 || bus.stack_empty !== 1'b1 || bus.stack_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got pc=%h empty=%b err=%b expected pc=00 empty=1 err=0",
               bus.pc, bus.stack_empty, bus.stack_err);
    end
    rst_n = 1'b1;
    idle_strobes();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_back_to_back();
    // pc=0x00: call pushes 0x01, then ret+call+jump together -> ret wins.
    bus.call   = 1'b1;
    bus.target = 8'h50;
    tick();
    bus.ret    = 1'b1;
    bus.jump   = 1'b1;
    bus.branch = 1'b1;
    bus.offset = 8'h10;
    bus.target = 8'h90;
    tick();
    checks++;
    if (bus.pc !== 8'h01 || bus.stack_empty !== 1'b1) begin
      errors++;
      $display("FAIL prio_ret: got pc=%h empty=%b expected pc=01 empty=1",
               bus.pc, bus.stack_empty);
    end
    bus.ret = 1'b0;
    tick();
    checks++;
    if (bus.pc !== 8'h90 || bus.stack_empty !== 1'b0) begin
      errors++;
      $display("FAIL prio_call: got pc=%h empty=%b expected pc=90 empty=0",
               bus.pc, bus.stack_empty);
    end
    bus.call = 1'b0;
    tick();
    checks++;
    if (bus.pc !== 8'h90) begin
      errors++;
      $display("FAIL prio_jump: got %h expected 90", bus.pc);
    end
    idle_strobes();
  endtask

  // -------------------------------------------------------------------------
  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    idle_strobes();
    #1;
    test_reset();
    test_increment();
    test_branch_jump();
    test_call_ret();
    test_overflow_underflow();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
